// File: rtl/func_sequencer.sv
// Queues operand pairs and runs the external cube-plus-product unit one pair at a time; results leave in order.
// Latency: function latency + 3 edges from pop to valid. Input stalls when the FIFO is full; results wait in HOLD.
module func_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               in_a_bi,
    input  logic [7:0]               in_b_bi,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [7:0]               fn_a_bo,
    output logic [7:0]               fn_b_bo,
    output logic                     fn_start_o,
    input  logic                     fn_busy_i,
    input  logic [23:0]              fn_result_bi,
    output logic [23:0]              out_result_bo,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_count_bo,
    output logic                     busy_o,
    output logic                     err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem_a [DEPTH];
    logic [7:0]      mem_b [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [WW-1:0]   wd;
    logic            push, pop, capture, abort, out_take, wd_expired;

    assign in_ready_o    = (count < CW'(DEPTH));
    assign push          = in_valid_i && in_ready_o;
    assign fifo_count_bo = count;
    assign busy_o        = (state != IDLE) || (count != '0);
    assign wd_expired    = (wd == WW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        out_take  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (wd_expired) begin
                    abort     = 1'b1;
                    state_nxt = HOLD;
                end else if (fn_busy_i) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (wd_expired) begin
                    abort     = 1'b1;
                    state_nxt = HOLD;
                end else if (!fn_busy_i) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    out_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a_bi;
            mem_b[wr_ptr] <= in_b_bi;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fn_a_bo       <= '0;
            fn_b_bo       <= '0;
            fn_start_o    <= 1'b0;
            out_result_bo <= '0;
            out_valid_o   <= 1'b0;
            err_o         <= 1'b0;
            wd            <= '0;
        end else begin
            fn_start_o <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                fn_a_bo <= mem_a[rd_ptr];
                fn_b_bo <= mem_b[rd_ptr];
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // Watchdog spans the whole handshake, from START until the result or abort.
            if (state == START)
                wd <= '0;
            else if (state == WAIT_ACK || state == WAIT_DONE)
                wd <= wd + 1'b1;
            if (capture) begin
                out_result_bo <= fn_result_bi;
                out_valid_o   <= 1'b1;
            end else if (abort) begin
                out_result_bo <= 24'hFFFFFF;
                out_valid_o   <= 1'b1;
                err_o         <= 1'b1;
            end else if (out_take) begin
                out_valid_o   <= 1'b0;
            end
        end
    end
endmodule
